fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction-fetch stage that feeds the decode/execute path. Holds the program counter, issues one request at a time to an instruction memory over a req/ready handshake, and presents one fetched instruction plus its PC+4 to decode through a one-deep output register with stall back-pressure. Consumes the redirect signals produced by execute (`do_branch`/`branch_addr`, `jump`/`jump_addr`) and flushes wrong-path fetches.

## Interface
- `RESET_PC`, 32'h0000_0000, PC loaded at reset; bits [1:0] must be 0.

- `clock`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `imem_req`  out  1  instruction request valid.
- `imem_addr`  out  32  request byte address, word aligned.
- `imem_ready`  in  1  one-cycle pulse: `imem_rdata` valid, request complete.
- `imem_rdata`  in  32  instruction word.
- `stall`  in  1  decode cannot accept the presented instruction this cycle.
- `do_branch`  in  1  taken-branch redirect from execute.
- `branch_addr`  in  32  branch target.
- `jump`  in  1  jump redirect from execute.
- `jump_addr`  in  32  jump target.
- `instruction`  out  32  fetched instruction.
- `pc4`  out  32  address of `instruction` + 4.
- `inst_valid`  out  1  `instruction`/`pc4` valid.

## Operation
- Registers: `pc`, `imem_addr`, `instruction`, `pc4`, `inst_valid`, `kill`, state {IDLE, REQ}.
- Consume: slot consumed in any cycle with `inst_valid`=1 and `stall`=0; `inst_valid` clears next edge unless refilled.
- `slot_free` = !`inst_valid` | !`stall`.
- IDLE: `imem_req`=0. If `slot_free` and no redirect this cycle: `imem_addr`<=`pc`, go REQ.
- REQ: `imem_req`=1; `imem_addr` stable until `imem_ready`. On `imem_ready`:
  - `kill`=0 and no redirect this cycle: `instruction`<=`imem_rdata`, `pc4`<=`imem_addr`+4, `inst_valid`<=1, `pc`<=`imem_addr`+4.
  - otherwise: data discarded, `kill`<=0.
  - always go IDLE.
- Slot is empty throughout REQ (entry needs `slot_free`; only a capture fills it), so capture never overwrites a live instruction.
- Redirect = `jump` | `do_branch`; target = `jump` ? `jump_addr` : `branch_addr` (jump wins). Target bits [1:0] forced to 0.
  - `pc`<=target; `inst_valid`<=0 (flush, overrides stall and consume).
  - In REQ without `imem_ready`: `kill`<=1; request continues to completion at old `imem_addr`, result discarded.
  - In REQ with `imem_ready`: data discarded same cycle.
  - Redirect during killed request: `pc` updated again, `kill` stays 1.
  - In IDLE: stay IDLE this cycle; request at target issued next cycle.
- Arithmetic: 32-bit unsigned, `imem_addr`+4 wraps 32'hFFFF_FFFC -> 32'h0000_0000.

## Timing
- Reset (async, immediate): `pc`=`RESET_PC`, `imem_req`=0, `imem_addr`=0, `instruction`=0, `pc4`=0, `inst_valid`=0, `kill`=0, state IDLE.
- Reset mid-request: `imem_req` drops asynchronously; the memory must tolerate an abandoned request; any later `imem_ready` in IDLE is ignored.
- First edge after reset release: IDLE->REQ; `imem_req`=1 with `imem_addr`=`RESET_PC` from cycle 1.
- Latency: `imem_ready` in cycle N -> `inst_valid`=1 in cycle N+1.
- Zero-wait memory, no stall: one instruction per 2 cycles (REQ, IDLE alternate).
- Memory with W wait cycles: one instruction per W+2 cycles.
- Redirect in cycle N with no outstanding request: `imem_addr`=target in cycle N+2.
- `imem_ready` outside REQ is ignored.

## Test plan
- Reset with `RESET_PC`=32'h0040_0000, zero-wait memory, `stall`=0 -> `imem_addr` sequence 0x00400000, 0x00400004, 0x00400008 on alternate cycles; first `inst_valid`=1 with `pc4`=0x00400004.
- `stall`=1 for 3 cycles while `inst_valid`=1 -> `instruction` and `pc4` stable, `imem_req`=0; after release, next request one cycle later at 0x00400008.
- Request outstanding with `imem_ready` delayed 3 cycles; `do_branch`=1, `branch_addr`=0x00400100 in wait cycle 1 -> returned word dropped, `inst_valid` stays 0, next `imem_addr`=0x00400100.
- `jump`=1, `jump_addr`=0x00400200 and `do_branch`=1, `branch_addr`=0x00400100 in same cycle -> next request at 0x00400200.
- `inst_valid`=1, `stall`=1, `jump`=1 -> `inst_valid`=0 next cycle, fetch resumes at `jump_addr`.
- `reset` asserted mid-REQ -> `imem_req`=0 without a clock edge; after release, first request at `RESET_PC`; stray `imem_ready` in IDLE produces no `inst_valid`.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues one outstanding imem request
// at a time, and holds one fetched instruction for decode with stall
// back-pressure. Execute redirects (jump/branch) flush the slot and any
// in-flight wrong-path fetch.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        do_branch,
  input  logic [31:0] branch_addr,
  input  logic        jump,
  input  logic [31:0] jump_addr,
  output logic [31:0] instruction,
  output logic [31:0] pc4,
  output logic        inst_valid
);

  localparam int unsigned XLEN = 32;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_REQ  = 1'b1;

  // architectural / pipeline state
  logic [0:0]      r_state;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_addr;
  logic [XLEN-1:0] r_inst;
  logic [XLEN-1:0] r_pc4;
  logic            r_valid;
  logic            r_kill;

  // next-state values
  logic [0:0]      w_state_nxt;
  logic [XLEN-1:0] w_pc_nxt;
  logic [XLEN-1:0] w_addr_nxt;
  logic [XLEN-1:0] w_inst_nxt;
  logic [XLEN-1:0] w_pc4_nxt;
  logic            w_valid_nxt;
  logic            w_kill_nxt;

  // derived control
  logic            w_redirect;
  logic [XLEN-1:0] w_raw_target;
  logic [XLEN-1:0] w_target;
  logic            w_slot_free;
  logic            w_consume;
  logic [XLEN-1:0] w_addr_plus4;

  // Redirect selection: jump has priority over a taken branch; targets are word aligned.
  always_comb begin
    w_redirect   = jump | do_branch;
    w_raw_target = jump ? jump_addr : branch_addr;
    w_target     = w_raw_target & ~XLEN'(3);
  end

  // Slot occupancy and sequential address arithmetic (wraps at 2^32).
  always_comb begin
    w_consume    = r_valid & ~stall;
    w_slot_free  = ~r_valid | ~stall;
    w_addr_plus4 = r_addr + XLEN'(4);
  end

  // Next-state logic for the fetch FSM and the output slot.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_addr_nxt  = r_addr;
    w_inst_nxt  = r_inst;
    w_pc4_nxt   = r_pc4;
    w_valid_nxt = r_valid;
    w_kill_nxt  = r_kill;

    if (w_consume) begin
      w_valid_nxt = 1'b0;
    end

    case (r_state)
      S_IDLE: begin
        // A redirect this cycle holds us in IDLE so the next request uses the new PC.
        if (!w_redirect && w_slot_free) begin
          w_addr_nxt  = r_pc;
          w_state_nxt = S_REQ;
        end
      end
      S_REQ: begin
        if (imem_ready) begin
          // The slot is always empty here, so a capture never overwrites live data.
          if (!r_kill && !w_redirect) begin
            w_inst_nxt  = imem_rdata;
            w_pc4_nxt   = w_addr_plus4;
            w_valid_nxt = 1'b1;
            w_pc_nxt    = w_addr_plus4;
          end
          w_kill_nxt  = 1'b0;
          w_state_nxt = S_IDLE;
        end else if (w_redirect) begin
          // Wrong-path request still completes at the old address; drop its data.
          w_kill_nxt = 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    // Flush wins over stall, consume and capture.
    if (w_redirect) begin
      w_pc_nxt    = w_target;
      w_valid_nxt = 1'b0;
    end
  end

  // State register with asynchronous active-low reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_pc    <= RESET_PC;
      r_addr  <= '0;
      r_inst  <= '0;
      r_pc4   <= '0;
      r_valid <= 1'b0;
      r_kill  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_addr  <= w_addr_nxt;
      r_inst  <= w_inst_nxt;
      r_pc4   <= w_pc4_nxt;
      r_valid <= w_valid_nxt;
      r_kill  <= w_kill_nxt;
    end
  end

  // Outputs are direct register decodes; imem_req drops as soon as reset is asserted.
  always_comb begin
    imem_req    = (r_state == S_REQ);
    imem_addr   = r_addr;
    instruction = r_inst;
    pc4         = r_pc4;
    inst_valid  = r_valid;
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios followed by randomized traffic,
// all checked every cycle against a transaction-level fetch model.
module tb_fetch_unit;

  localparam logic [31:0] RPC = 32'h0040_0000;

  logic        clock = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        do_branch;
  logic [31:0] branch_addr;
  logic        jump;
  logic [31:0] jump_addr;
  logic [31:0] instruction;
  logic [31:0] pc4;
  logic        inst_valid;

  int total = 0;
  int bad   = 0;

  // model state: fetch PC, outstanding request, output slot
  logic [31:0] m_pc, m_addr, m_inst, m_pc4;
  bit          m_valid, m_busy, m_kill;
  int          wleft, mem_wait;

  // per-cycle stimulus chosen by the sequence
  bit          d_stall, d_br, d_j, d_stray;
  logic [31:0] d_baddr, d_jaddr;

  fetch_unit #(.RESET_PC(RPC)) dut (
    .clock       (clock),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rdata  (imem_rdata),
    .stall       (stall),
    .do_branch   (do_branch),
    .branch_addr (branch_addr),
    .jump        (jump),
    .jump_addr   (jump_addr),
    .instruction (instruction),
    .pc4         (pc4),
    .inst_valid  (inst_valid)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = RPC; m_addr = '0; m_inst = '0; m_pc4 = '0;
    m_valid = 0; m_busy = 0; m_kill = 0; wleft = 0;
  endtask

  // Check outputs, drive one cycle of inputs, advance the model, move to next negedge.
  task automatic step();
    logic        rdy, redir, free;
    logic [31:0] rd, tgt;
    check("imem_req",    32'(imem_req),   32'(m_busy));
    check("imem_addr",   imem_addr,       m_addr);
    check("inst_valid",  32'(inst_valid), 32'(m_valid));
    check("instruction", instruction,     m_inst);
    check("pc4",         pc4,             m_pc4);

    rdy = 1'b0;
    if (m_busy) begin
      if (wleft == 0) rdy = 1'b1;
      else wleft--;
    end else begin
      rdy = d_stray;
    end
    rd = (rdy && m_busy) ? word_at(m_addr) : $urandom;

    stall = d_stall; do_branch = d_br; branch_addr = d_baddr;
    jump = d_j; jump_addr = d_jaddr; imem_ready = rdy; imem_rdata = rd;

    redir = d_br | d_j;
    tgt   = (d_j ? d_jaddr : d_baddr) & 32'hFFFF_FFFC;
    free  = !m_valid || !d_stall;
    if (m_valid && !d_stall) m_valid = 0;
    if (m_busy) begin
      if (rdy) begin
        if (!m_kill && !redir) begin
          m_valid = 1; m_inst = rd; m_pc4 = m_addr + 32'd4; m_pc = m_addr + 32'd4;
        end
        m_kill = 0; m_busy = 0;
      end else if (redir) begin
        m_kill = 1;
      end
    end else if (!redir && free) begin
      m_addr = m_pc; m_busy = 1; wleft = mem_wait;
    end
    if (redir) begin
      m_pc = tgt; m_valid = 0;
    end

    @(posedge clock);
    @(negedge clock);
  endtask

  initial begin
    reset = 1'b0; imem_ready = 0; imem_rdata = '0; stall = 0;
    do_branch = 0; branch_addr = '0; jump = 0; jump_addr = '0;
    d_stall = 0; d_br = 0; d_j = 0; d_stray = 0; d_baddr = '0; d_jaddr = '0;
    mem_wait = 0;
    model_reset();

    repeat (2) @(negedge clock);
    check("rst_req",   32'(imem_req),   32'd0);
    check("rst_addr",  imem_addr,       32'd0);
    check("rst_valid", 32'(inst_valid), 32'd0);
    check("rst_inst",  instruction,     32'd0);
    check("rst_pc4",   pc4,             32'd0);
    reset = 1'b1;

    // zero-wait sequential fetch
    step();                                             // c0 IDLE
    check("c1_addr", imem_addr, 32'h0040_0000);
    check("c1_req", 32'(imem_req), 32'd1);
    step();
    check("c2_valid", 32'(inst_valid), 32'd1);
    check("c2_pc4", pc4, 32'h0040_0004);
    step();
    check("c3_addr", imem_addr, 32'h0040_0004);
    step();
    check("c4_pc4", pc4, 32'h0040_0008);
    d_stall = 1;
    step();
    // stall holds the slot and blocks new requests
    check("stall_req", 32'(imem_req), 32'd0);
    check("stall_pc4", pc4, 32'h0040_0008);
    check("stall_valid", 32'(inst_valid), 32'd1);
    step();
    check("stall_inst", instruction, word_at(32'h0040_0004));
    step();
    d_stall = 0; mem_wait = 3;
    check("stall_rel_req", 32'(imem_req), 32'd0);
    step();
    check("resume_addr", imem_addr, 32'h0040_0008);
    check("resume_req", 32'(imem_req), 32'd1);

    // branch during wait cycle 1 kills the outstanding fetch
    d_br = 1; d_baddr = 32'h0040_0100;
    step();
    d_br = 0;
    repeat (3) step();
    check("kill_valid", 32'(inst_valid), 32'd0);
    check("kill_req", 32'(imem_req), 32'd0);
    mem_wait = 0;
    step();
    check("br_addr", imem_addr, 32'h0040_0100);
    step();
    check("br_pc4", pc4, 32'h0040_0104);

    // jump and branch together: jump wins
    d_j = 1; d_jaddr = 32'h0040_0200; d_br = 1; d_baddr = 32'h0040_0100;
    step();
    d_j = 0; d_br = 0;
    check("jb_idle_req", 32'(imem_req), 32'd0);
    check("jb_flush", 32'(inst_valid), 32'd0);
    step();
    check("jb_addr", imem_addr, 32'h0040_0200);
    step();
    check("jb_pc4", pc4, 32'h0040_0204);

    // jump flushes a stalled instruction
    d_stall = 1; d_j = 1; d_jaddr = 32'h0040_0300;
    step();
    d_stall = 0; d_j = 0;
    check("sj_flush", 32'(inst_valid), 32'd0);
    step();
    check("sj_addr", imem_addr, 32'h0040_0300);
    step();
    mem_wait = 4;
    step();

    // asynchronous reset in the middle of a request
    check("pre_rst_req", 32'(imem_req), 32'd1);
    #2 reset = 1'b0;
    #1;
    check("async_req_drop", 32'(imem_req), 32'd0);
    check("async_addr", imem_addr, 32'd0);
    model_reset();
    mem_wait = 0;
    imem_ready = 1'b1;
    @(negedge clock);
    imem_ready = 1'b0;
    reset = 1'b1;
    d_stray = 1;
    step();
    d_stray = 0;
    check("rr_addr", imem_addr, RPC);
    check("rr_req", 32'(imem_req), 32'd1);
    check("rr_stray_valid", 32'(inst_valid), 32'd0);
    step();

    // randomized traffic
    for (int i = 0; i < 800; i++) begin
      d_stall  = ($urandom % 10) < 3;
      d_br     = ($urandom % 16) == 0;
      d_j      = ($urandom % 20) == 0;
      d_baddr  = $urandom;
      d_jaddr  = (($urandom % 4) == 0) ? (32'hFFFF_FFF0 | 32'($urandom % 16)) : $urandom;
      d_stray  = ($urandom % 5) == 0;
      mem_wait = int'($urandom % 4);
      step();
    end
    d_stall = 0; d_br = 0; d_j = 0; d_stray = 0;
    repeat (4) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
